dmem_port_arbiter: RTL

//   Shares the single data-memory port (RAM array plus memory-mapped switches,

---
 rtl/dmem_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two requesters,
// with bounded bursts and a registered read-return path per requester.
module dmem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] a0,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          rv0,
    output logic          rv1,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

    localparam int             BCW     = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] BC_MAX  = BCW'(MAX_BURST);
    localparam logic [BCW-1:0] BC_LAST = BCW'(MAX_BURST - 1);

    state_t         r_state, w_state_nxt, w_oth_state;
    logic           r_last, w_last_nxt;
    logic [BCW-1:0] r_bc, w_bc_nxt;
    logic [DW-1:0]  r_rd0, r_rd1;
    logic           r_rv0, r_rv1;
    logic           w_own_req, w_oth_req;

    assign gnt0 = (r_state == S_OWN0) && req0 && !reset;
    assign gnt1 = (r_state == S_OWN1) && req1 && !reset;
    assign rd0  = r_rd0;
    assign rd1  = r_rd1;
    // A read return already registered when reset arrives is dropped, not delivered.
    assign rv0  = r_rv0 && !reset;
    assign rv1  = r_rv1 && !reset;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (gnt0) begin
            mem_we = we0;
            mem_a  = a0;
            mem_wd = wd0;
        end else if (gnt1) begin
            mem_we = we1;
            mem_a  = a1;
            mem_wd = wd1;
        end
    end

    always_comb begin
        w_own_req   = 1'b0;
        w_oth_req   = 1'b0;
        w_oth_state = S_IDLE;
        if (r_state == S_OWN0) begin
            w_own_req   = req0;
            w_oth_req   = req1;
            w_oth_state = S_OWN1;
        end else if (r_state == S_OWN1) begin
            w_own_req   = req1;
            w_oth_req   = req0;
            w_oth_state = S_OWN0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bc_nxt    = r_bc;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (req0 && req1)  w_state_nxt = r_last ? S_OWN0 : S_OWN1;
                else if (req0)     w_state_nxt = S_OWN0;
                else if (req1)     w_state_nxt = S_OWN1;
            end
            S_OWN0, S_OWN1: begin
                if (!w_own_req) begin
                    w_state_nxt = w_oth_req ? w_oth_state : S_IDLE;
                end else begin
                    if (r_bc != BC_MAX) w_bc_nxt = r_bc + BCW'(1);
                    // >= so a requester arriving after bc saturated still waits only one beat.
                    if (w_oth_req && (r_bc >= BC_LAST)) w_state_nxt = w_oth_state;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if ((w_state_nxt != r_state) && (w_state_nxt != S_IDLE)) begin
            w_bc_nxt   = '0;
            w_last_nxt = (w_state_nxt == S_OWN1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_bc    <= '0;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_bc    <= w_bc_nxt;
            r_rv0   <= gnt0 && !we0;
            r_rv1   <= gnt1 && !we1;
            if (gnt0 && !we0) r_rd0 <= mem_rd;
            if (gnt1 && !we1) r_rd1 <= mem_rd;
        end
    end

endmodule
